// File: rtl/hazard_ctrl_pkg.sv
// Shared pipeline-hazard types: controller FSM state encoding and operand-forward select codes.
package hazard_ctrl_pkg;

  typedef enum logic [1:0] {
    StRun     = 2'd0,
    StMemWait = 2'd1,
    StError   = 2'd2
  } hz_state_e;

  localparam logic [1:0] FWD_NONE = 2'b00;
  localparam logic [1:0] FWD_W    = 2'b01;
  localparam logic [1:0] FWD_M    = 2'b10;

endpackage

// File: rtl/fwd_sel.sv
// Operand-forward select for one execute-stage source register; memory stage wins over writeback.
module fwd_sel #(
  parameter int unsigned REG_AW = 5
) (
  input  logic [REG_AW-1:0] rs,
  input  logic [REG_AW-1:0] rd_m,
  input  logic [REG_AW-1:0] rd_w,
  input  logic              reg_write_m,
  input  logic              reg_write_w,
  output logic [1:0]        fwd
);
  import hazard_ctrl_pkg::*;

  // x0 is hardwired to zero, so it is never a forwarding source.
  always_comb begin
    fwd = FWD_NONE;
    if (reg_write_m && (rd_m != '0) && (rd_m == rs)) begin
      fwd = FWD_M;
    end else if (reg_write_w && (rd_w != '0) && (rd_w == rs)) begin
      fwd = FWD_W;
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: forwarding, load-use and redirect handling, memory-wait FSM with
// timeout error, and saturating stall/flush performance counters.
module hazard_ctrl #(
  parameter int unsigned REG_AW      = 5,
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned MEM_TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_AW-1:0] Rs1_D,
  input  logic [REG_AW-1:0] Rs2_D,
  input  logic [REG_AW-1:0] Rs1_E,
  input  logic [REG_AW-1:0] Rs2_E,
  input  logic [REG_AW-1:0] RD_E,
  input  logic [REG_AW-1:0] RD_M,
  input  logic [REG_AW-1:0] RD_W,
  input  logic              RegWriteM,
  input  logic              RegWriteW,
  input  logic              ResultSrcE,
  input  logic              PCSrcE,
  input  logic              mem_req_M,
  input  logic              mem_ready_M,
  output logic [1:0]        ForwardAE,
  output logic [1:0]        ForwardBE,
  output logic              StallF,
  output logic              StallD,
  output logic              StallE,
  output logic              StallM,
  output logic              FlushD,
  output logic              FlushE,
  output logic              FlushW,
  output logic              hz_err,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);
  import hazard_ctrl_pkg::*;

  localparam int unsigned WcW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [WcW-1:0] WaitLast = WcW'(MEM_TIMEOUT - 1);

  hz_state_e      state_q, state_d;
  logic [WcW-1:0] wait_cnt_q, wait_cnt_d;
  logic           lw_stall;
  logic           mem_stall;

  fwd_sel #(
    .REG_AW (REG_AW)
  ) u_fwd_a (
    .rs          (Rs1_E),
    .rd_m        (RD_M),
    .rd_w        (RD_W),
    .reg_write_m (RegWriteM),
    .reg_write_w (RegWriteW),
    .fwd         (ForwardAE)
  );

  fwd_sel #(
    .REG_AW (REG_AW)
  ) u_fwd_b (
    .rs          (Rs2_E),
    .rd_m        (RD_M),
    .rd_w        (RD_W),
    .reg_write_m (RegWriteM),
    .reg_write_w (RegWriteW),
    .fwd         (ForwardBE)
  );

  assign lw_stall  = ResultSrcE && (RD_E != '0) && ((RD_E == Rs1_D) || (RD_E == Rs2_D));
  // Once timed out the memory stage never completes, so the pipeline stays frozen.
  assign mem_stall = (state_q == StError) ? 1'b1 : (mem_req_M && !mem_ready_M);
  assign hz_err    = (state_q == StError);

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = '0;
    unique case (state_q)
      StRun: begin
        if (mem_stall) state_d = StMemWait;
      end
      StMemWait: begin
        if (mem_ready_M) begin
          state_d = StRun;
        end else if (wait_cnt_q == WaitLast) begin
          state_d = StError;
        end else begin
          wait_cnt_d = wait_cnt_q + WcW'(1);
        end
      end
      StError: state_d = StError;
      default: state_d = StRun;
    endcase
  end

  // Memory stall dominates redirect, which dominates load-use.
  always_comb begin
    StallF = 1'b0;
    StallD = 1'b0;
    StallE = 1'b0;
    StallM = 1'b0;
    FlushD = 1'b0;
    FlushE = 1'b0;
    FlushW = 1'b0;
    if (mem_stall) begin
      StallF = 1'b1;
      StallD = 1'b1;
      StallE = 1'b1;
      StallM = 1'b1;
      FlushW = 1'b1;
    end else if (PCSrcE) begin
      FlushD = 1'b1;
      FlushE = 1'b1;
    end else if (lw_stall) begin
      StallF = 1'b1;
      StallD = 1'b1;
      FlushE = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= StRun;
      wait_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (StallF && (stall_cnt != '1)) stall_cnt <= stall_cnt + CNT_W'(1);
      if ((FlushD || FlushE) && (flush_cnt != '1)) flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 The block SHALL have parameter REG_AW, default 5, meaning register-address width.
REQ-002 The block SHALL have parameter CNT_W, default 16, meaning width of each performance counter.
REQ-003 The block SHALL have parameter MEM_TIMEOUT, default 64, meaning the maximum consecutive memory-wait cycles before the error state.
REQ-004 The block SHALL have these ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- Rs1_D, Rs2_D  in  REG_AW  decode-stage source registers.
- Rs1_E, Rs2_E, RD_E  in  REG_AW  execute-stage source and destination registers.
- RD_M, RD_W  in  REG_AW  memory-stage and writeback-stage destination registers.
- RegWriteM, RegWriteW  in  1  write enables for the memory and writeback stages.
- ResultSrcE  in  1  a load is in the execute stage.
- PCSrcE  in  1  branch or jump redirect taken in the execute stage.
- mem_req_M  in  1  data-memory access pending in the memory stage.
- mem_ready_M  in  1  data memory completes this cycle.
- ForwardAE, ForwardBE  out  2  operand-forward selects.
- StallF, StallD, StallE, StallM  out  1  stage holds.
- FlushD, FlushE, FlushW  out  1  bubble inserts.
- hz_err  out  1  memory timeout, sticky.
- stall_cnt, flush_cnt  out  CNT_W  performance counters.

Function
REQ-005 ForwardAE SHALL be 2'b10 if RegWriteM && RD_M!=0 && RD_M==Rs1_E; else 2'b01 if RegWriteW && RD_W!=0 && RD_W==Rs1_E; else 2'b00.
REQ-006 ForwardBE SHALL follow the REQ-005 rule using Rs2_E.
REQ-007 lw_stall SHALL be ResultSrcE && RD_E!=0 && (RD_E==Rs1_D || RD_E==Rs2_D).
REQ-008 mem_stall SHALL be (mem_req_M && !mem_ready_M) in states RUN and MEM_WAIT, and SHALL be 1 in state ERROR.
REQ-009 FSM states SHALL be RUN, MEM_WAIT and ERROR, with these transitions:
- RUN to MEM_WAIT on mem_stall.
- MEM_WAIT to RUN on mem_ready_M.
- MEM_WAIT to ERROR when wait_cnt reaches MEM_TIMEOUT-1 with mem_ready_M=0.
- ERROR is held until reset.
REQ-010 wait_cnt SHALL clear in RUN, increment each MEM_WAIT cycle, and clear on exit from MEM_WAIT.
REQ-011 When mem_stall=1, StallF, StallD, StallE, StallM and FlushW SHALL be 1, and FlushD and FlushE SHALL be 0; lw_stall and PCSrcE are ignored that cycle.
REQ-012 When mem_stall=0 and PCSrcE=1, FlushD and FlushE SHALL be 1 and StallF and StallD SHALL be 0, even if lw_stall=1.
REQ-013 When mem_stall=0, PCSrcE=0 and lw_stall=1, StallF, StallD and FlushE SHALL be 1.
REQ-014 All control outputs not asserted by REQ-011 to REQ-013 SHALL be 0.
REQ-015 Forwarding outputs SHALL be independent of stall and flush state.
REQ-016 All outputs except counters and hz_err SHALL be combinational, with zero-cycle latency from their inputs.
REQ-017 stall_cnt SHALL increment on each clock edge where StallF=1, saturating at all-ones.
REQ-018 flush_cnt SHALL increment on each clock edge where FlushD or FlushE is 1, saturating at all-ones.
REQ-019 hz_err SHALL be 1 exactly when the state is ERROR.

Reset
REQ-020 With rst=0, state SHALL be RUN, wait_cnt 0, stall_cnt 0, flush_cnt 0 and hz_err 0, immediately and independent of clk.
REQ-021 Reset asserted during MEM_WAIT or ERROR SHALL return the block to RUN, with combinational outputs then driven purely by inputs.
REQ-022 The first state update SHALL occur on the first rising clk edge after rst deasserts.

Structure
REQ-023 The FSM state encoding and the forward-select constants (FWD_NONE=00, FWD_W=01, FWD_M=10) SHALL reside in a shared package, also used by execute_cycle.
REQ-024 One sub-module, fwd_sel, SHALL implement REQ-005, instantiated once per operand.
REQ-025 Counters and the FSM SHALL reside in hazard_ctrl.

Verification
REQ-026 The bench SHALL cover each of the following directed scenarios:
- RegWriteM=1, RD_M=5, RegWriteW=1, RD_W=5, Rs1_E=5 -> ForwardAE=10; with RD_M=0 -> 01.
- ResultSrcE=1, RD_E=7, Rs2_D=7 -> StallF=StallD=FlushE=1; then add PCSrcE=1 -> FlushD=FlushE=1, StallF=0.
- mem_req_M=1, mem_ready_M=0 for 3 cycles, then 1 -> all stalls and FlushW=1 for 3 cycles, RUN on the 4th edge, stall_cnt=3.
- MEM_TIMEOUT=4, mem_ready_M held 0 -> ERROR after the 4th wait cycle, hz_err=1 sticky, then rst=0 mid-cycle -> hz_err=0 immediately.
- CNT_W=3, 9 consecutive PCSrcE cycles -> flush_cnt saturates at 7.
